// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - handshaked doubleword data memory with programmable wait states
module dmem_responder #(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    input  logic        resp_ready
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_write;
    logic            r_bad;
    logic [AW-1:0]   r_idx;
    logic [63:0]     r_wdata;
    logic [63:0]     r_rdata;
    logic            r_err;
    logic [63:0]     mem [DEPTH];

    logic            w_req_bad;
    logic            w_in_idle;
    logic            w_acc_write;
    logic            w_acc_bad;
    logic [AW-1:0]   w_acc_idx;
    logic [63:0]     w_acc_wdata;
    logic [63:0]     w_rd_val;
    logic            w_do_access;

    assign w_req_bad = (req_addr[2:0] != 3'b000) || (req_addr[63:3] >= 61'(DEPTH));

    // With zero wait states the access happens on the accept edge, so it must
    // use the live request rather than the registers being loaded on that edge.
    assign w_in_idle   = (r_state == S_IDLE);
    assign w_acc_write = w_in_idle ? req_write : r_write;
    assign w_acc_bad   = w_in_idle ? w_req_bad : r_bad;
    assign w_acc_idx   = w_in_idle ? req_addr[3+AW-1:3] : r_idx;
    assign w_acc_wdata = w_in_idle ? req_wdata : r_wdata;
    assign w_rd_val    = (w_acc_write || w_acc_bad) ? 64'd0 : mem[w_acc_idx];

    assign w_do_access = rst_n &&
                         ((w_in_idle && req_valid && (WAIT_CYCLES == 0)) ||
                          (r_state == S_BUSY && r_cnt == '0));

    assign req_ready  = w_in_idle && rst_n;
    assign resp_valid = (r_state == S_RESP) && rst_n;
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_write <= 1'b0;
            r_bad   <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_write <= req_write;
                        r_bad   <= w_req_bad;
                        r_idx   <= req_addr[3+AW-1:3];
                        r_wdata <= req_wdata;
                        if (WAIT_CYCLES == 0) begin
                            r_rdata <= w_rd_val;
                            r_err   <= w_acc_bad;
                            r_state <= S_RESP;
                        end else begin
                            r_cnt   <= CW'(WAIT_CYCLES - 1);
                            r_state <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    if (r_cnt == '0) begin
                        r_rdata <= w_rd_val;
                        r_err   <= w_acc_bad;
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    if (resp_ready) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Array is deliberately left out of reset; contents survive rst_n.
    always_ff @(posedge clk) begin
        if (w_do_access && w_acc_write && !w_acc_bad)
            mem[w_acc_idx] <= w_acc_wdata;
    end
endmodule
